// File: rtl/pdm_demodulator.sv
// PDM demodulator: counts ones over back-to-back 2**WINDOW_LOG2-cycle windows.
// It scales and saturates each count into a WIDTH-bit sample on a valid/ready output.
// Optional input synchroniser: define PDM_DEMOD_SYNC_EN.
module pdm_demodulator #(
  parameter int WIDTH       = 5,
  parameter int WINDOW_LOG2 = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pdm_in,
  input  logic             enable,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sample_out,
  output logic             out_valid,
  output logic             overrun
);

  localparam int SHIFT = WINDOW_LOG2 - WIDTH;
  localparam logic [WINDOW_LOG2-1:0] WLAST = '1;
  localparam logic [WINDOW_LOG2:0]   SAT   =
    {{(WINDOW_LOG2 + 1 - WIDTH){1'b0}}, {WIDTH{1'b1}}};

  logic [WINDOW_LOG2-1:0] wcnt_q, wcnt_d;
  logic [WINDOW_LOG2:0]   acc_q, acc_d;
  logic [WIDTH-1:0]       sample_q, sample_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   bit_s;
  logic [WINDOW_LOG2:0]   count;
  logic [WINDOW_LOG2:0]   scaled;
  logic                   win_end;
  logic                   xfer;

`ifdef PDM_DEMOD_SYNC_EN
  logic sync1_q, sync2_q;

  // Synchroniser runs regardless of enable, so a new window first sees stale history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pdm_in;
      sync2_q <= sync1_q;
    end
  end

  assign bit_s = sync2_q;
`else
  assign bit_s = pdm_in;
`endif

  // Output handshake: a sample transfers on any edge with out_valid & out_ready;
  // out_valid stays high until then, and a fresh sample landing on an
  // unaccepted one overwrites it and raises the sticky overrun flag.
  assign xfer    = valid_q & out_ready;
  assign win_end = enable & (wcnt_q == WLAST);
  assign count   = acc_q + {{WINDOW_LOG2{1'b0}}, bit_s};
  assign scaled  = count >> SHIFT;

  always_comb begin
    wcnt_d    = wcnt_q;
    acc_d     = acc_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (xfer) begin
      valid_d = 1'b0;
    end
    if (!enable) begin
      wcnt_d    = '0;
      acc_d     = '0;
      overrun_d = 1'b0;
    end else if (win_end) begin
      wcnt_d   = '0;
      acc_d    = '0;
      sample_d = (scaled > SAT) ? {WIDTH{1'b1}} : scaled[WIDTH-1:0];
      valid_d  = 1'b1;
      if (valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end
    end else begin
      wcnt_d = wcnt_q + 1'b1;
      acc_d  = count;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_q    <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_out = sample_q;
  assign out_valid  = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pdm_demodulator.sv
// Directed bench for pdm_demodulator (default build: WIDTH=5, WINDOW_LOG2=5, no synchroniser).
module tb_pdm_demodulator;

  logic       clk;
  logic       reset_n;
  logic       pdm_in;
  logic       enable;
  logic       out_ready;
  logic [4:0] sample_out;
  logic       out_valid;
  logic       overrun;

  int n_assert;
  int n_fail;

  pdm_demodulator #(.WIDTH(5), .WINDOW_LOG2(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pdm_in     (pdm_in),
    .enable     (enable),
    .out_ready  (out_ready),
    .sample_out (sample_out),
    .out_valid  (out_valid),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full window, bit i of pattern on the i-th edge; out_ready becomes
  // rdy from the second edge on (the first edge keeps the caller's value).
  task automatic drive_window(input logic [31:0] pattern, input logic rdy);
    for (int i = 0; i < 32; i++) begin
      pdm_in = pattern[i];
      if (i == 1) out_ready = rdy;
      tick();
    end
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    pdm_in    = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #3;
    chk("reset_sample", 32'(sample_out), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    run(2);
    #2 reset_n = 1'b1;

    // 1: all ones saturates to 31, valid one cycle in 32
    enable    = 1'b1;
    pdm_in    = 1'b1;
    out_ready = 1'b1;
    run(31);
    chk("t1_no_valid_before_end", 32'(out_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_sample_sat", 32'(sample_out), 32'd31);
    tick();
    chk("t1_valid_drop", 32'(out_valid), 32'd0);
    run(30);
    chk("t1_valid_low_midwin", 32'(out_valid), 32'd0);
    tick();
    chk("t1_valid2", 32'(out_valid), 32'd1);
    chk("t1_sample2", 32'(sample_out), 32'd31);

    // 2: all zeros
    pdm_in = 1'b0;
    run(32);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_sample", 32'(sample_out), 32'd0);
    chk("t2_overrun", 32'(overrun), 32'd0);

    // 3: density 8/32 and 26/32
    drive_window(32'h1111_1111, 1'b1);
    chk("t3_sample8", 32'(sample_out), 32'd8);
    chk("t3_valid8", 32'(out_valid), 32'd1);
    drive_window(32'hF7DF_7DF3, 1'b1);
    chk("t3_sample26", 32'(sample_out), 32'd26);

    // 4: two windows without acceptance
    drive_window(32'h1111_1111, 1'b0);
    chk("t4_sample8", 32'(sample_out), 32'd8);
    chk("t4_no_overrun_yet", 32'(overrun), 32'd0);
    drive_window(32'h5555_5555, 1'b0);
    chk("t4_sample16", 32'(sample_out), 32'd16);
    chk("t4_overrun", 32'(overrun), 32'd1);
    chk("t4_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("t4_accept_valid", 32'(out_valid), 32'd0);
    chk("t4_overrun_sticky", 32'(overrun), 32'd1);
    enable = 1'b0;
    tick();
    chk("t4_overrun_clear", 32'(overrun), 32'd0);
    chk("t4_sample_hold", 32'(sample_out), 32'd16);

    // 5: drop enable mid-window; the partial window must not leak
    enable = 1'b1;
    pdm_in = 1'b1;
    run(10);
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    for (int i = 0; i < 31; i++) begin
      pdm_in = (i < 4) ? 1'b1 : 1'b0;
      tick();
      chk("t5_no_early_valid", 32'(out_valid), 32'd0);
    end
    pdm_in = 1'b0;
    tick();
    chk("t5_valid", 32'(out_valid), 32'd1);
    chk("t5_sample_fresh", 32'(sample_out), 32'd4);

    // 6: async reset between edges, with valid and overrun both set
    out_ready = 1'b0;
    drive_window(32'hFFFF_FFFF, 1'b0);
    chk("t6_pre_overrun", 32'(overrun), 32'd1);
    run(5);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_sample", 32'(sample_out), 32'd0);
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_overrun", 32'(overrun), 32'd0);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    drive_window(32'h1111_1111, 1'b1);
    chk("t6_post_sample", 32'(sample_out), 32'd8);
    chk("t6_post_valid", 32'(out_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
